rsa_xcel_mont_modexp_sched: RTL and testbench

Round-robin scheduler that shares one Montgomery modular-exponentiation unit (96-bit request, 32-bit result, val/rdy streams) among NREQ independent requesters. It accepts one request at a time, forwards it to the unit, captures the unit's result, and returns it to the requester that issued it. It sits between the accelerator's per-port request/response queues and the single modexp instance. At most one transaction is in flight at any time.

---
 rtl/rsa_xcel_mont_modexp_sched.sv | 139 +++++++++++++
 tb/tb_rsa_xcel_mont_modexp_sched.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_xcel_mont_modexp_sched.sv
// rtl/rsa_xcel_mont_modexp_sched.sv - round-robin scheduler sharing one modexp unit among NREQ requesters
module rsa_xcel_mont_modexp_sched #(
    parameter  int NREQ = 4,
    localparam int GW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ*96-1:0] req_msg,
    input  logic [NREQ-1:0]    req_val,
    output logic [NREQ-1:0]    req_rdy,
    output logic [NREQ*32-1:0] resp_msg,
    output logic [NREQ-1:0]    resp_val,
    input  logic [NREQ-1:0]    resp_rdy,
    output logic [95:0]        mx_istream_msg,
    output logic               mx_istream_val,
    input  logic               mx_istream_rdy,
    input  logic [31:0]        mx_ostream_msg,
    input  logic               mx_ostream_val,
    output logic               mx_ostream_rdy,
    output logic [GW-1:0]      owner,
    output logic               busy,
    output logic [15:0]        done_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [GW-1:0] rr_ptr_q, rr_ptr_d;
    logic [GW-1:0] owner_q, owner_d;
    logic [95:0]   msg_q, msg_d;
    logic [31:0]   res_q, res_d;
    logic [15:0]   done_q, done_d;

    logic          grant_any;
    logic [GW-1:0] grant_idx;
    logic [GW-1:0] grant_next;

    // First valid requester at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            int idx;
            idx = int'(rr_ptr_q) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!grant_any && req_val[idx]) begin
                grant_any = 1'b1;
                grant_idx = GW'(idx);
            end
        end
        grant_next = (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + GW'(1);
    end

    // Next-state and handshake logic; rr_ptr only moves when a grant actually fires.
    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        owner_d        = owner_q;
        msg_d          = msg_q;
        res_d          = res_q;
        done_d         = done_q;
        req_rdy        = '0;
        resp_val       = '0;
        mx_istream_val = 1'b0;
        mx_ostream_rdy = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    req_rdy[grant_idx] = 1'b1;
                    msg_d              = req_msg[96*grant_idx +: 96];
                    owner_d            = grant_idx;
                    rr_ptr_d           = grant_next;
                    state_d            = SEND;
                end
            end
            SEND: begin
                mx_istream_val = 1'b1;
                if (mx_istream_rdy) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                mx_ostream_rdy = 1'b1;
                if (mx_ostream_val) begin
                    res_d   = mx_ostream_msg;
                    state_d = RESP;
                end
            end
            RESP: begin
                resp_val[owner_q] = 1'b1;
                if (resp_rdy[owner_q]) begin
                    done_d  = done_q + 16'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Response data is steered only to the owning port; every other slice reads zero.
    always_comb begin
        resp_msg = '0;
        if (state_q == RESP) begin
            resp_msg[32*owner_q +: 32] = res_q;
        end
    end

    assign mx_istream_msg = (state_q == SEND) ? msg_q : '0;
    assign owner          = owner_q;
    assign busy           = (state_q != IDLE);
    assign done_count     = done_q;

    // State registers; reset abandons any in-flight transaction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            msg_q    <= '0;
            res_q    <= '0;
            done_q   <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            msg_q    <= msg_d;
            res_q    <= res_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: tb/tb_rsa_xcel_mont_modexp_sched.sv
// tb/tb_rsa_xcel_mont_modexp_sched.sv - directed scoreboard bench for the modexp scheduler
module tb_rsa_xcel_mont_modexp_sched;

    localparam int NREQ = 4;
    localparam int GW   = 2;

    logic               clk = 1'b0;
    logic               reset;
    logic [NREQ*96-1:0] req_msg;
    logic [NREQ-1:0]    req_val;
    logic [NREQ-1:0]    req_rdy;
    logic [NREQ*32-1:0] resp_msg;
    logic [NREQ-1:0]    resp_val;
    logic [NREQ-1:0]    resp_rdy;
    logic [95:0]        mx_istream_msg;
    logic               mx_istream_val;
    logic               mx_istream_rdy;
    logic [31:0]        mx_ostream_msg;
    logic               mx_ostream_val;
    logic               mx_ostream_rdy;
    logic [GW-1:0]      owner;
    logic               busy;
    logic [15:0]        done_count;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int exp_done = 0;

    int          exp_port_q[$];
    logic [31:0] exp_res_q[$];
    logic [95:0] unit_msg;

    rsa_xcel_mont_modexp_sched #(.NREQ(NREQ)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_msg        (req_msg),
        .req_val        (req_val),
        .req_rdy        (req_rdy),
        .resp_msg       (resp_msg),
        .resp_val       (resp_val),
        .resp_rdy       (resp_rdy),
        .mx_istream_msg (mx_istream_msg),
        .mx_istream_val (mx_istream_val),
        .mx_istream_rdy (mx_istream_rdy),
        .mx_ostream_msg (mx_ostream_msg),
        .mx_ostream_val (mx_ostream_val),
        .mx_ostream_rdy (mx_ostream_rdy),
        .owner          (owner),
        .busy           (busy),
        .done_count     (done_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] modexp(input logic [95:0] m);
        logic [63:0] b, r, md;
        logic [31:0] e;
        b  = {32'd0, m[95:64]};
        e  = m[63:32];
        md = {32'd0, m[31:0]};
        r  = 64'd1 % md;
        b  = b % md;
        for (int i = 0; i < 32; i++) begin
            if (e[i]) r = (r * b) % md;
            b = (b * b) % md;
        end
        return r[31:0];
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int port, input logic [31:0] b, input logic [31:0] e,
                           input logic [31:0] m, input bit push);
        req_msg[96*port +: 96] = {b, e, m};
        req_val[port]          = 1'b1;
        if (push) begin
            exp_port_q.push_back(port);
            exp_res_q.push_back(modexp({b, e, m}));
        end
    endtask

    // Called just after a negedge with req_val already driven; returns at the negedge in SEND.
    task automatic accept(input int port, input bit drop);
        #1;
        check("idle_busy", {127'd0, busy}, 128'd0);
        check("grant_rdy", {124'd0, req_rdy}, 128'(1) << port);
        @(negedge clk);
        if (drop) req_val[port] = 1'b0;
    endtask

    task automatic send(input int port, input int stall);
        logic [95:0] exp_msg;
        exp_msg = req_msg[96*port +: 96];
        check("send_owner", {126'd0, owner}, 128'(port));
        for (int i = 0; i < stall; i++) begin
            mx_istream_rdy = 1'b0;
            check("send_stall_val", {127'd0, mx_istream_val}, 128'd1);
            check("send_stall_msg", {32'd0, mx_istream_msg}, {32'd0, exp_msg});
            check("send_stall_reqrdy", {124'd0, req_rdy}, 128'd0);
            @(negedge clk);
        end
        check("send_val", {127'd0, mx_istream_val}, 128'd1);
        check("send_msg", {32'd0, mx_istream_msg}, {32'd0, exp_msg});
        check("send_ordy", {127'd0, mx_ostream_rdy}, 128'd0);
        unit_msg       = mx_istream_msg;
        mx_istream_rdy = 1'b1;
        @(negedge clk);
        mx_istream_rdy = 1'b0;
    endtask

    task automatic reply();
        check("wait_ordy", {127'd0, mx_ostream_rdy}, 128'd1);
        check("wait_ival", {127'd0, mx_istream_val}, 128'd0);
        mx_ostream_val = 1'b1;
        mx_ostream_msg = modexp(unit_msg);
        @(negedge clk);
        mx_ostream_val = 1'b0;
        mx_ostream_msg = 32'd0;
    endtask

    task automatic respond(input int stall);
        int          port;
        logic [31:0] res;
        if (exp_port_q.size() == 0) begin
            check("scoreboard_empty", 128'd1, 128'd0);
            return;
        end
        port = exp_port_q.pop_front();
        res  = exp_res_q.pop_front();
        check("resp_owner", {126'd0, owner}, 128'(port));
        for (int i = 0; i < stall; i++) begin
            resp_rdy = ~(4'(1) << port);
            check("resp_stall_val", {124'd0, resp_val}, 128'(1) << port);
            check("resp_stall_msg", resp_msg, {96'd0, res} << (32 * port));
            check("resp_stall_reqrdy", {124'd0, req_rdy}, 128'd0);
            @(negedge clk);
        end
        check("resp_val", {124'd0, resp_val}, 128'(1) << port);
        check("resp_msg", resp_msg, {96'd0, res} << (32 * port));
        resp_rdy = 4'(1) << port;
        @(negedge clk);
        resp_rdy = '0;
        exp_done++;
        check("done_count", {112'd0, done_count}, 128'(exp_done));
        check("resp_idle_val", {124'd0, resp_val}, 128'd0);
    endtask

    task automatic full_txn(input int port, input bit drop, input int s_stall, input int r_stall);
        accept(port, drop);
        send(port, s_stall);
        reply();
        respond(r_stall);
    endtask

    task automatic check_reset_outputs();
        check("rst_req_rdy", {124'd0, req_rdy}, 128'd0);
        check("rst_resp_val", {124'd0, resp_val}, 128'd0);
        check("rst_resp_msg", resp_msg, 128'd0);
        check("rst_ival", {127'd0, mx_istream_val}, 128'd0);
        check("rst_imsg", {32'd0, mx_istream_msg}, 128'd0);
        check("rst_ordy", {127'd0, mx_ostream_rdy}, 128'd0);
        check("rst_owner", {126'd0, owner}, 128'd0);
        check("rst_busy", {127'd0, busy}, 128'd0);
        check("rst_done", {112'd0, done_count}, 128'd0);
    endtask

    initial begin
        reset          = 1'b0;
        req_msg        = '0;
        req_val        = '0;
        resp_rdy       = '0;
        mx_istream_rdy = 1'b0;
        mx_ostream_msg = 32'd0;
        mx_ostream_val = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs();
        reset = 1'b1;
        @(negedge clk);

        // Single request on port 2: 4^13 mod 497 = 445.
        check("model_445", {96'd0, modexp({32'd4, 32'd13, 32'd497})}, 128'd445);
        set_req(2, 32'd4, 32'd13, 32'd497, 1'b1);
        full_txn(2, 1'b1, 0, 0);

        // All ports valid continuously after reset: grants 0,1,2,3,0.
        reset = 1'b0;
        @(negedge clk);
        reset    = 1'b1;
        exp_done = 0;
        @(negedge clk);
        set_req(0, 32'd3, 32'd7, 32'd1000, 1'b1);
        set_req(1, 32'd5, 32'd11, 32'd977, 1'b1);
        set_req(2, 32'd7, 32'd5, 32'd101, 1'b1);
        set_req(3, 32'd9, 32'd9, 32'd8191, 1'b1);
        exp_port_q.push_back(0);
        exp_res_q.push_back(modexp({32'd3, 32'd7, 32'd1000}));
        full_txn(0, 1'b0, 0, 0);
        full_txn(1, 1'b0, 0, 0);
        full_txn(2, 1'b0, 0, 0);
        full_txn(3, 1'b0, 0, 0);
        accept(0, 1'b0);
        req_val = '0;
        send(0, 0);
        reply();
        respond(0);
        check("rr_done5", {112'd0, done_count}, 128'd5);

        // Move rr_ptr to 2, then ports 1 and 3 together: 3 first, then 1.
        set_req(1, 32'd2, 32'd10, 32'd1025, 1'b1);
        full_txn(1, 1'b1, 0, 0);
        set_req(1, 32'd6, 32'd3, 32'd50, 1'b0);
        set_req(3, 32'd8, 32'd4, 32'd77, 1'b1);
        exp_port_q.push_back(1);
        exp_res_q.push_back(modexp({32'd6, 32'd3, 32'd50}));
        full_txn(3, 1'b1, 0, 0);
        full_txn(1, 1'b1, 0, 0);

        // Backpressure in SEND and RESP while port 0 waits its turn.
        set_req(2, 32'd11, 32'd17, 32'd65537, 1'b1);
        set_req(0, 32'd13, 32'd2, 32'd1000, 1'b1);
        full_txn(2, 1'b1, 5, 4);
        check("stall_single_done", {112'd0, done_count}, 128'd9);
        full_txn(0, 1'b1, 0, 0);

        // Spurious unit result while idle must not be consumed.
        mx_ostream_val = 1'b1;
        mx_ostream_msg = 32'hdead_beef;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("spur_ordy", {127'd0, mx_ostream_rdy}, 128'd0);
            check("spur_resp_val", {124'd0, resp_val}, 128'd0);
            check("spur_busy", {127'd0, busy}, 128'd0);
            @(negedge clk);
        end
        mx_ostream_val = 1'b0;
        mx_ostream_msg = 32'd0;
        check("spur_done", {112'd0, done_count}, 128'd10);

        // Reset while waiting on the unit; rr_ptr was 2 before reset.
        set_req(1, 32'd4, 32'd13, 32'd497, 1'b1);
        accept(1, 1'b1);
        send(1, 0);
        check("pre_rst_wait", {127'd0, mx_ostream_rdy}, 128'd1);
        reset = 1'b0;
        #1;
        check_reset_outputs();
        exp_port_q.delete();
        exp_res_q.delete();
        exp_done = 0;
        @(negedge clk);
        reset = 1'b1;
        set_req(2, 32'd5, 32'd3, 32'd13, 1'b0);
        set_req(0, 32'd7, 32'd2, 32'd10, 1'b1);
        exp_port_q.push_back(2);
        exp_res_q.push_back(modexp({32'd5, 32'd3, 32'd13}));
        full_txn(0, 1'b1, 0, 0);
        full_txn(2, 1'b1, 0, 0);
        check("post_rst_done", {112'd0, done_count}, 128'd2);
        check("scoreboard_drained", 128'(exp_port_q.size()), 128'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
